// File: rtl/stopwatch_pkg.sv
// Shared state encoding, field widths and limits for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } sw_state_e;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HR_W    = 5;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, time/lap/status readout out; the controller uses the slave side.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic             start_stop;
    logic             lap;
    logic             clear;
    logic             running;
    logic             paused;
    logic [SEC_W-1:0] sec;
    logic [MIN_W-1:0] min;
    logic [HR_W-1:0]  hr;
    logic             sec_tick;
    logic             overflow;
    logic             lap_valid;
    logic [SEC_W-1:0] lap_sec;
    logic [MIN_W-1:0] lap_min;
    logic [HR_W-1:0]  lap_hr;

    modport master (
        output start_stop, lap, clear,
        input  running, paused, sec, min, hr, sec_tick, overflow,
        input  lap_valid, lap_sec, lap_min, lap_hr
    );

    modport slave (
        input  start_stop, lap, clear,
        output running, paused, sec, min, hr, sec_tick, overflow,
        output lap_valid, lap_sec, lap_min, lap_hr
    );

endinterface

// File: rtl/wrap_counter.sv
// Counter that wraps from MAX to 0 when enabled; carry is combinational so stages chain.
module wrap_counter #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         zero_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] value_q, value_d;

    assign carry_o = en_i && (value_q == MaxVal);
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (zero_i || carry_o) begin
            value_d = '0;
        end else if (en_i) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: prescaled one-second tick, sec/min/hr cascade, lap snapshot.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned HOURS_MAX = 23
) (
    input logic             clk,
    input logic             rst_n,
    stopwatch_ctrl_if.slave sw_io
);

    localparam int unsigned     PscW    = $clog2(TICK_DIV);
    localparam logic [PscW-1:0] PscLast = PscW'(TICK_DIV - 1);

    sw_state_e        state_q, state_d;
    logic [PscW-1:0]  psc_q, psc_d;
    logic             tick, lap_cap, clr_evt;
    logic             sec_carry, min_carry, hr_carry;
    logic [SEC_W-1:0] sec_val;
    logic [MIN_W-1:0] min_val;
    logic [HR_W-1:0]  hr_val;

    logic             running_q, paused_q, sec_tick_q, overflow_q;
    logic             lap_valid_q, lap_valid_d;
    logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
    logic [MIN_W-1:0] lap_min_q, lap_min_d;
    logic [HR_W-1:0]  lap_hr_q, lap_hr_d;

    assign tick    = (state_q == StRun) && (psc_q == PscLast);
    assign lap_cap = (state_q == StRun) && sw_io.lap;
    assign clr_evt = (state_q == StPause) && sw_io.clear;

    // Clear wins over start_stop in PAUSE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sw_io.start_stop) state_d = StRun;
            StRun:   if (sw_io.start_stop) state_d = StPause;
            StPause: begin
                if (sw_io.clear) begin
                    state_d = StIdle;
                end else if (sw_io.start_stop) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Held in PAUSE so a resume only counts the remainder of the second.
    always_comb begin
        psc_d = psc_q;
        if (state_q == StRun) begin
            psc_d = tick ? '0 : psc_q + PscW'(1);
        end else if (state_d == StIdle) begin
            psc_d = '0;
        end
    end

    always_comb begin
        lap_valid_d = lap_valid_q;
        lap_sec_d   = lap_sec_q;
        lap_min_d   = lap_min_q;
        lap_hr_d    = lap_hr_q;
        if (clr_evt) begin
            lap_valid_d = 1'b0;
            lap_sec_d   = '0;
            lap_min_d   = '0;
            lap_hr_d    = '0;
        end else if (lap_cap) begin
            lap_valid_d = 1'b1;
            lap_sec_d   = sec_val;
            lap_min_d   = min_val;
            lap_hr_d    = hr_val;
        end
    end

    wrap_counter #(
        .MAX(SEC_MAX),
        .W  (SEC_W)
    ) u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (tick),
        .zero_i (clr_evt),
        .value_o(sec_val),
        .carry_o(sec_carry)
    );

    wrap_counter #(
        .MAX(MIN_MAX),
        .W  (MIN_W)
    ) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (sec_carry),
        .zero_i (clr_evt),
        .value_o(min_val),
        .carry_o(min_carry)
    );

    wrap_counter #(
        .MAX(HOURS_MAX),
        .W  (HR_W)
    ) u_hr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (min_carry),
        .zero_i (clr_evt),
        .value_o(hr_val),
        .carry_o(hr_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            psc_q       <= '0;
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
            sec_tick_q  <= 1'b0;
            overflow_q  <= 1'b0;
            lap_valid_q <= 1'b0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_hr_q    <= '0;
        end else begin
            state_q     <= state_d;
            psc_q       <= psc_d;
            running_q   <= (state_d == StRun);
            paused_q    <= (state_d == StPause);
            sec_tick_q  <= tick;
            overflow_q  <= hr_carry;
            lap_valid_q <= lap_valid_d;
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
            lap_hr_q    <= lap_hr_d;
        end
    end

    assign sw_io.running   = running_q;
    assign sw_io.paused    = paused_q;
    assign sw_io.sec       = sec_val;
    assign sw_io.min       = min_val;
    assign sw_io.hr        = hr_val;
    assign sw_io.sec_tick  = sec_tick_q;
    assign sw_io.overflow  = overflow_q;
    assign sw_io.lap_valid = lap_valid_q;
    assign sw_io.lap_sec   = lap_sec_q;
    assign sw_io.lap_min   = lap_min_q;
    assign sw_io.lap_hr    = lap_hr_q;

endmodule
